// File: rtl/spi_cmd_fifo_reader.sv
// Pops 41-bit command words from a FIFO and plays each one out as a mode-0 SPI
// frame; for read commands the last 32 MISO bits are returned on resp_data.
module spi_cmd_fifo_reader #(
    parameter int DATA_WIDTH = 41,
    parameter int CLK_DIV    = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] NBITS    = 6'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [5:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [31:0]           rx_q, rx_d;
    logic                  wr_q, wr_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  rv_q, rv_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  pop;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            wr_q    <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            rv_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            wr_q    <= wr_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        wr_d    = wr_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_FETCH;
                end
            end
            // Read data is valid during FETCH, so the word is captured as LOAD is
            // entered; LOAD then counts as the first divider cycle of bit 40.
            S_FETCH: begin
                state_d = S_LOAD;
                sh_d    = fifo_rd_data;
                wr_d    = fifo_rd_data[DATA_WIDTH-1];
                cs_n_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
                rx_d    = '0;
            end
            S_LOAD, S_SHIFT: begin
                state_d = S_SHIFT;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[30:0], miso};
                        bit_d  = bit_q + 6'd1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == NBITS) begin
                            state_d = S_HOLD;
                            cs_n_d  = 1'b1;
                            sh_d    = '0;
                            if (!wr_q) begin
                                rv_d    = 1'b1;
                                rdata_d = rx_q;
                            end
                        end else begin
                            sh_d = sh_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by reset so no pop can reach the FIFO while the block is held in reset.
    assign fifo_rd_en = pop & rd_rst_n;
    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign mosi       = sh_q[DATA_WIDTH-1];
    assign resp_valid = rv_q;
    assign resp_data  = rdata_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_fifo_reader.sv
// Randomized scoreboard bench: FIFO + SPI slave models feed the main instance,
// a second instance checks the slowest divider on a single write.
module tb_spi_cmd_fifo_reader;
    localparam int DIV  = 2;
    localparam int ADIV = 255;
    localparam int DW   = 41;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic          rd_rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en, sclk, cs_n, mosi, resp_valid, busy;
    logic          miso = 1'b0;
    logic [31:0]   resp_data;

    logic          a_rst_n, a_empty, a_miso, a_rd_en, a_sclk, a_cs_n, a_mosi, a_rv, a_busy;
    logic [DW-1:0] a_data;
    logic [31:0]   a_rdata;

    spi_cmd_fifo_reader #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) u_dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso), .resp_valid(resp_valid),
        .resp_data(resp_data), .busy(busy));

    spi_cmd_fifo_reader #(.DATA_WIDTH(DW), .CLK_DIV(ADIV)) u_dut_slow (
        .rd_clk(rd_clk), .rd_rst_n(a_rst_n), .fifo_empty(a_empty),
        .fifo_rd_data(a_data), .fifo_rd_en(a_rd_en), .sclk(a_sclk),
        .cs_n(a_cs_n), .mosi(a_mosi), .miso(a_miso), .resp_valid(a_rv),
        .resp_data(a_rdata), .busy(a_busy));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // FIFO model: words indexed by push/pop counters
    logic [DW-1:0] mem [0:255];
    int  push_cnt = 0;
    int  pop_cnt  = 0;
    bit  stall    = 1'b0;
    assign fifo_empty = (push_cnt == pop_cnt) || stall;

    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[pop_cnt[7:0]];
            pop_cnt      <= pop_cnt + 1;
        end
    end

    // Scoreboard: expected frames, slave reply words, expected read responses
    logic [DW-1:0] cmd_q [$];
    logic [31:0]   slv_q [$];
    logic [31:0]   rsp_q [$];

    task automatic push_word(input logic [DW-1:0] w, input logic [31:0] s);
        mem[push_cnt[7:0]] = w;
        cmd_q.push_back(w);
        slv_q.push_back(s);
        if (!w[DW-1]) rsp_q.push_back(s);
        push_cnt++;
    endtask

    // Monitor / SPI slave
    bit            prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0;
    bit            gap_on = 1'b0, gap_full = 1'b0, hold_on = 1'b0;
    int            rises = 0, half = 0, low = 0, gap_cnt = 0, hold_cnt = 0;
    logic [DW-1:0] rx = '0, exp_cmd;
    logic [31:0]   slv = '0, model_resp = '0;

    always @(negedge rd_clk) begin
        if (!rd_rst_n) begin
            in_frame = 1'b0; gap_on = 1'b0; hold_on = 1'b0;
            prev_cs = 1'b1; prev_sclk = 1'b0; model_resp = '0;
        end else begin
            if (fifo_rd_en) chk("rd_en_only_idle_nonempty", {fifo_empty, busy}, 2'b00);
            if (resp_valid) begin
                chk("resp_at_hold_entry", {prev_cs, cs_n}, 2'b01);
                if (rsp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    model_resp = rsp_q.pop_front();
                    chk("resp_data", resp_data, model_resp);
                end
            end
            if (hold_on) begin
                if (busy) hold_cnt++;
                else begin
                    chk("hold_len", hold_cnt, DIV);
                    hold_on = 1'b0;
                end
            end
            if (prev_cs && !cs_n) begin
                if (gap_on) begin
                    if (gap_full) chk("b2b_cs_gap", gap_cnt, DIV + 2);
                    else          chk("min_cs_gap", gap_cnt >= DIV + 2, 1);
                end
                gap_on = 1'b0;
                chk("busy_in_frame", busy, 1);
                in_frame = 1'b1; rises = 0; half = 1; low = 1; rx = '0;
                if (slv_q.size() > 0) slv = slv_q.pop_front();
                else begin
                    chk("frame_unexpected", 1, 0);
                    slv = '0;
                end
                miso = 1'($urandom);
            end else if (in_frame) begin
                if (sclk != prev_sclk) begin
                    chk("half_period", half, DIV);
                    half = 1;
                    if (sclk) begin
                        rises++;
                        rx = {rx[DW-2:0], mosi};
                    end else if (rises >= 9 && rises <= 40) miso = slv[40-rises];
                    else miso = 1'($urandom);
                end else half++;
                if (cs_n) begin
                    in_frame = 1'b0;
                    chk("sclk_pulses", rises, 41);
                    chk("end_sclk_mosi", {sclk, mosi}, 2'b00);
                    chk("cs_low_len", low, 82 * DIV);
                    if (cmd_q.size() == 0) chk("cmd_q_empty", 1, 0);
                    else begin
                        exp_cmd = cmd_q.pop_front();
                        chk("frame_cmd", rx, exp_cmd);
                        chk("resp_valid_vs_cmd", resp_valid, !exp_cmd[DW-1]);
                    end
                    chk("resp_data_held", resp_data, model_resp);
                    gap_on = 1'b1; gap_cnt = 1; gap_full = !fifo_empty;
                    hold_on = 1'b1; hold_cnt = 1;
                end else low++;
            end else if (gap_on && cs_n) begin
                gap_cnt++;
                if (fifo_empty) gap_full = 1'b0;
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
        end
    end

    task automatic wait_idle(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge rd_clk); #1;
            ok = (push_cnt == pop_cnt) && (cmd_q.size() == 0) && !busy && cs_n && !in_frame;
        end
        chk("drain_in_time", ok, 1);
    endtask

    // Slow-divider instance: one write, every half period exactly ADIV cycles
    bit aux_done = 1'b0;
    initial begin
        int a_pops = 0, a_rises = 0, a_half = 0, a_bad = 0;
        bit a_prev_cs = 1'b1, a_prev_sclk = 1'b0, a_in = 1'b0, a_seen_rv = 1'b0, a_end = 1'b0;
        logic [DW-1:0] a_rx = '0;
        a_rst_n = 1'b1; a_empty = 1'b1; a_miso = 1'b0; a_data = 41'h1_5A_C0FFEE11;
        #3 a_rst_n = 1'b0;
        #20 a_rst_n = 1'b1;
        @(posedge rd_clk); #1 a_empty = 1'b0;
        for (int i = 0; i < 25000 && !a_end; i++) begin
            @(negedge rd_clk);
            if (a_pops > 0) a_empty = 1'b1;
            if (a_rd_en) a_pops++;
            if (a_rv) a_seen_rv = 1'b1;
            if (a_prev_cs && !a_cs_n) begin
                a_in = 1'b1; a_half = 1;
            end else if (a_in) begin
                if (a_sclk != a_prev_sclk) begin
                    if (a_half != ADIV) a_bad++;
                    a_half = 1;
                    if (a_sclk) begin
                        a_rises++;
                        a_rx = {a_rx[DW-2:0], a_mosi};
                    end
                end else a_half++;
                if (a_cs_n) a_end = 1'b1;
            end
            a_prev_cs = a_cs_n;
            a_prev_sclk = a_sclk;
        end
        chk("slow_frame_done", a_end, 1);
        chk("slow_pops", a_pops, 1);
        chk("slow_pulses", a_rises, 41);
        chk("slow_half_periods_bad", a_bad, 0);
        chk("slow_frame_cmd", a_rx, a_data);
        chk("slow_no_resp", {a_seen_rv, a_rdata}, 0);
        aux_done = 1'b1;
    end

    initial begin
        bit ok;
        bit found;
        logic [DW-1:0] w;
        rd_rst_n = 1'b1;
        #3 rd_rst_n = 1'b0;
        #1;
        chk("reset_outputs", {fifo_rd_en, sclk, cs_n, mosi, resp_valid, busy}, 6'b001000);
        chk("reset_resp_data", resp_data, 0);
        #20 rd_rst_n = 1'b1;

        ok = 1'b1;
        repeat (100) begin
            @(negedge rd_clk);
            if (fifo_rd_en || busy || !cs_n || sclk) ok = 1'b0;
        end
        chk("idle_when_empty", ok, 1);

        @(posedge rd_clk); #1 push_word(41'h1_A5_DEADBEEF, $urandom);
        wait_idle(600);
        @(posedge rd_clk); #1 push_word(41'h0_3C_00000000, 32'h12345678);
        wait_idle(600);

        @(posedge rd_clk); #1;
        push_word({1'b0, 8'($urandom), 32'($urandom)}, $urandom);
        push_word({1'b1, 8'($urandom), 32'($urandom)}, $urandom);
        wait_idle(1000);

        for (int n = 0; n < 30; n++) begin
            stall = 1'b0;
            for (int t = 0; t < 2000 && (push_cnt - pop_cnt) >= 3; t++) @(posedge rd_clk);
            @(posedge rd_clk); #1;
            w = {1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom)};
            push_word(w, $urandom);
            stall = ($urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 120)) @(posedge rd_clk);
        end
        stall = 1'b0;
        wait_idle(8000);

        // Abort a read at sclk pulse 20; the queued write must follow cleanly
        @(posedge rd_clk); #1;
        push_word({1'b0, 8'h77, 32'h0}, $urandom);
        push_word({1'b1, 8'($urandom), 32'($urandom)}, $urandom);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge rd_clk); #1;
            found = in_frame && (rises == 20);
        end
        chk("reached_pulse_20", found, 1);
        rd_rst_n = 1'b0;
        #1;
        chk("abort_outputs", {cs_n, sclk, mosi, resp_valid, busy, fifo_rd_en}, 6'b100000);
        chk("abort_resp_data", resp_data, 0);
        void'(cmd_q.pop_front());
        void'(rsp_q.pop_front());
        @(negedge rd_clk);
        chk("no_pop_in_reset", {fifo_rd_en, fifo_empty}, 2'b00);
        @(negedge rd_clk); #2 rd_rst_n = 1'b1;
        wait_idle(800);
        chk("abort_resp_data_after", resp_data, 0);

        for (int i = 0; i < 30000 && !aux_done; i++) @(posedge rd_clk);
        chk("slow_check_finished", aux_done, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_fifo_reader.md
SPI_CMD_FIFO_READER -- requirements
Module: spi_cmd_fifo_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 41, the FIFO command word width (fixed 41: [40] write flag, [39:32] address, [31:0] data).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, the SPI half-period in rd_clk cycles (legal range 1..255).
REQ-003 rd_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rd_rst_n  input  1  asynchronous active-low reset.
REQ-005 fifo_empty  input  1  asynchronous FIFO read-side empty flag.
REQ-006 fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 fifo_rd_en  output  1  FIFO pop strobe, one-cycle pulse.
REQ-008 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 cs_n  output  1  SPI chip select, active low.
REQ-010 mosi  output  1  SPI serial data out, MSB first.
REQ-011 miso  input  1  SPI serial data in (synchronous to sclk).
REQ-012 resp_valid  output  1  one-cycle pulse, read response available.
REQ-013 resp_data  output  32  read response data, held until next read completes.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, LOAD, SHIFT, HOLD.
REQ-016 In IDLE with fifo_empty=0, the block SHALL assert fifo_rd_en for exactly one cycle and enter FETCH.
REQ-017 fifo_rd_en SHALL never be asserted while fifo_empty=1 or outside IDLE.
REQ-018 FETCH SHALL last one cycle, then enter LOAD.
REQ-019 LOAD SHALL capture fifo_rd_data into a 41-bit shift register, drive cs_n=0 and mosi=bit 40, clear the divider and bit counter, and enter SHIFT next cycle.
REQ-020 In SHIFT, sclk SHALL rise after CLK_DIV cycles and fall after a further CLK_DIV cycles; each bit period is 2*CLK_DIV cycles.
REQ-021 miso SHALL be sampled on the rd_clk edge that raises sclk; mosi SHALL change only on the edge that lowers sclk.
REQ-022 Exactly 41 sclk pulses SHALL occur per transaction; bits sent in order [40] down to [0].
REQ-023 On the 41st sclk falling edge, the block SHALL drive cs_n=1, sclk=0, mosi=0 and enter HOLD.
REQ-024 For a read (bit 40=0), the 32 miso samples on sclk rises 10..41 SHALL form resp_data MSB-first; resp_data SHALL update and resp_valid SHALL pulse for one cycle on entry to HOLD.
REQ-025 For a write (bit 40=1), miso SHALL be ignored, resp_valid SHALL stay 0 and resp_data SHALL be unchanged.
REQ-026 HOLD SHALL last CLK_DIV cycles with cs_n=1, then enter IDLE.
REQ-027 Back-to-back words SHALL give a minimum cs_n-high gap of CLK_DIV+2 cycles (HOLD + IDLE + FETCH).
REQ-028 fifo_empty SHALL be sampled only in IDLE; changes during a transaction SHALL have no effect.
REQ-029 The divider counter SHALL be 8 bits and the bit counter 6 bits; neither SHALL wrap within a transaction.

Reset
REQ-030 On rd_rst_n=0, asynchronously: state=IDLE, fifo_rd_en=0, sclk=0, cs_n=1, mosi=0, resp_valid=0, resp_data=0, busy=0, and all counters and the shift register cleared.
REQ-031 Reset mid-transaction SHALL abort immediately; the popped word is discarded and no resp_valid is produced.
REQ-032 After reset deassertion, the first fifo_rd_en SHALL occur no earlier than the first rd_clk edge with fifo_empty=0.

Verification
REQ-033 CLK_DIV=2, fifo_rd_data=41'h1_A5_DEADBEEF -> one fifo_rd_en pulse; mosi serialises 1, 8'hA5, 32'hDEADBEEF; 41 sclk pulses of 4 cycles each; cs_n low for 164 cycles; no resp_valid.
REQ-034 CLK_DIV=2, word 41'h0_3C_00000000, slave drives 32'h12345678 on miso in bits 10..41 -> resp_valid one cycle at HOLD entry with resp_data=32'h12345678.
REQ-035 fifo_empty=1 for 100 cycles -> fifo_rd_en, busy and cs_n toggle never; sclk stays 0.
REQ-036 Two words queued back-to-back, CLK_DIV=1 -> exactly two fifo_rd_en pulses; cs_n high gap of 3 cycles between frames; no rd_en during the first frame.
REQ-037 rd_rst_n low at sclk pulse 20 of a read -> cs_n=1, sclk=0 asynchronously; no resp_valid; resp_data=0; next queued word is sent cleanly after reset release.
REQ-038 CLK_DIV=255, single write -> each sclk half-period exactly 255 cycles; no counter wrap.
